// File: rtl/vga_logo_scheduler.sv
// Once-per-frame bouncing-logo position, direction and palette scheduler.
// Optional mode auto-cycling is built when LOGO_SCHED_AUTOMODE_EN is defined.
module vga_logo_scheduler #(
    parameter int LOGO_SIZE      = 128,
    parameter int DISPLAY_WIDTH  = 640,
    parameter int DISPLAY_HEIGHT = 480,
    parameter int START_X        = 200,
    parameter int START_Y        = 200,
    parameter int MODE_PERIOD    = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       pause,
    input  logic [1:0] speed,
    output logic       frame_tick,
    output logic [9:0] logo_left,
    output logic [9:0] logo_top,
    output logic       dir_x,
    output logic       dir_y,
    output logic [2:0] color_index,
    output logic [1:0] mode
);

    localparam logic [10:0] MAX_X = 11'(DISPLAY_WIDTH - LOGO_SIZE);
    localparam logic [10:0] MAX_Y = 11'(DISPLAY_HEIGHT - LOGO_SIZE);
    localparam logic [9:0]  EVT_Y = 10'(DISPLAY_HEIGHT);

    if (MODE_PERIOD < 1) begin : g_bad_mode_period
        $error("MODE_PERIOD must be at least 1");
    end

    // Returns {hit, new_dir, new_pos}; 11-bit arithmetic so the sum never wraps.
    function automatic logic [11:0] axis_next(input logic [9:0]  pos,
                                              input logic        dir,
                                              input logic [10:0] step,
                                              input logic [10:0] lim);
        logic [10:0] sum;
        logic [10:0] dif;
        sum = {1'b0, pos} + step;
        dif = {1'b0, pos} - step;
        if (dir) begin
            if (sum >= lim) return {1'b1, 1'b0, lim[9:0]};
            else            return {1'b0, 1'b1, sum[9:0]};
        end else begin
            if ({1'b0, pos} <= step) return {1'b1, 1'b1, 10'd0};
            else                     return {1'b0, 1'b0, dif[9:0]};
        end
    endfunction

    logic        w_evt;
    logic [10:0] w_step;
    logic [11:0] w_nx;
    logic [11:0] w_ny;

    logic        r_tick;
    logic [9:0]  r_left;
    logic [9:0]  r_top;
    logic        r_dir_x;
    logic        r_dir_y;
    logic [2:0]  r_color;

    assign w_evt  = (pix_x == 10'd0) && (pix_y == EVT_Y);
    assign w_step = 11'(speed) + 11'd1;
    assign w_nx   = axis_next(r_left, r_dir_x, w_step, MAX_X);
    assign w_ny   = axis_next(r_top,  r_dir_y, w_step, MAX_Y);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick  <= 1'b0;
            r_left  <= 10'(START_X);
            r_top   <= 10'(START_Y);
            r_dir_x <= 1'b1;
            r_dir_y <= 1'b0;
            r_color <= 3'd0;
        end else begin
            r_tick <= w_evt;
            if (w_evt && !pause) begin
                r_left  <= w_nx[9:0];
                r_dir_x <= w_nx[10];
                r_top   <= w_ny[9:0];
                r_dir_y <= w_ny[10];
                // A corner hit still advances the palette by a single step.
                if (w_nx[11] || w_ny[11]) r_color <= r_color + 3'd1;
            end
        end
    end

`ifdef LOGO_SCHED_AUTOMODE_EN
    localparam int CNT_W = (MODE_PERIOD > 1) ? $clog2(MODE_PERIOD) : 1;

    logic [CNT_W-1:0] r_frame_cnt;
    logic [1:0]       r_mode;

    // Counts every frame event, paused or not.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_mode      <= 2'd0;
        end else if (w_evt) begin
            if (r_frame_cnt == CNT_W'(MODE_PERIOD - 1)) begin
                r_frame_cnt <= '0;
                r_mode      <= r_mode + 2'd1;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign mode = r_mode;
`else
    assign mode = 2'b00;
`endif

    assign frame_tick  = r_tick;
    assign logo_left   = r_left;
    assign logo_top    = r_top;
    assign dir_x       = r_dir_x;
    assign dir_y       = r_dir_y;
    assign color_index = r_color;

endmodule

// File: tb/tb_vga_logo_scheduler.sv
// Directed bench for vga_logo_scheduler; a second instance starts near the corner.
module tb_vga_logo_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] pix_x, pix_y;
    logic [9:0] pix_cx, pix_cy;
    logic       pause;
    logic [1:0] speed;

    logic       frame_tick, dir_x, dir_y;
    logic [9:0] logo_left, logo_top;
    logic [2:0] color_index;
    logic [1:0] mode;

    logic       c_tick, c_dir_x, c_dir_y;
    logic [9:0] c_left, c_top;
    logic [2:0] c_color;
    logic [1:0] c_mode;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;
    int n_ev = 0;
    int t0;

    always #5 clk = ~clk;

    vga_logo_scheduler u_dut (
        .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
        .pause(pause), .speed(speed), .frame_tick(frame_tick),
        .logo_left(logo_left), .logo_top(logo_top), .dir_x(dir_x), .dir_y(dir_y),
        .color_index(color_index), .mode(mode)
    );

    vga_logo_scheduler #(.START_X(510), .START_Y(2)) u_cor (
        .clk(clk), .reset(reset), .pix_x(pix_cx), .pix_y(pix_cy),
        .pause(pause), .speed(speed), .frame_tick(c_tick),
        .logo_left(c_left), .logo_top(c_top), .dir_x(c_dir_x), .dir_y(c_dir_y),
        .color_index(c_color), .mode(c_mode)
    );

    always @(negedge clk) if (frame_tick === 1'b1) tick_cnt++;

    function automatic int exp_mode(input int e);
`ifdef LOGO_SCHED_AUTOMODE_EN
        return (e / 120) % 4;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ev();
        pix_x = 10'd0;
        pix_y = 10'd480;
        step();
        pix_x = 10'd5;
        pix_y = 10'd100;
        n_ev++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            ev();
            step();
        end
    endtask

    initial begin
        reset = 1'b1; pause = 1'b0; speed = 2'd0;
        pix_x = 10'd5; pix_y = 10'd100; pix_cx = 10'd5; pix_cy = 10'd100;
        step(); step(); step();
        chk("rst_left", 32'(logo_left), 200);
        chk("rst_top", 32'(logo_top), 200);
        chk("rst_dirx", 32'(dir_x), 1);
        chk("rst_diry", 32'(dir_y), 0);
        chk("rst_color", 32'(color_index), 0);
        chk("rst_tick", 32'(frame_tick), 0);
        chk("rst_mode", 32'(mode), 0);
        chk("rst_cor_left", 32'(c_left), 510);
        reset = 1'b0;
        step();

        ev();
        chk("ev1_left", 32'(logo_left), 201);
        chk("ev1_top", 32'(logo_top), 199);
        chk("ev1_tick", 32'(frame_tick), 1);
        chk("ev1_color", 32'(color_index), 0);
        step();
        chk("ev1_tick_low", 32'(frame_tick), 0);

        t0 = tick_cnt;
        pix_x = 10'd1;   pix_y = 10'd480; pause = 1'b1; speed = 2'd3; step();
        pix_x = 10'd0;   pix_y = 10'd479; speed = 2'd2; step();
        pix_x = 10'd0;   pix_y = 10'd481; pause = 1'b0; step();
        pix_x = 10'd639; pix_y = 10'd480; step();
        pix_x = 10'd5;   pix_y = 10'd100; speed = 2'd0; step();
        chk("noev_left", 32'(logo_left), 201);
        chk("noev_top", 32'(logo_top), 199);
        chk("noev_ticks", 32'(tick_cnt - t0), 0);
        chk("noev_color", 32'(color_index), 0);

        t0 = tick_cnt;
        run(199);
        chk("topwall_top", 32'(logo_top), 0);
        chk("topwall_diry", 32'(dir_y), 1);
        chk("topwall_color", 32'(color_index), 1);
        chk("topwall_left", 32'(logo_left), 400);
        chk("topwall_ticks", 32'(tick_cnt - t0), 199);

        run(112);
        chk("rwall_left", 32'(logo_left), 512);
        chk("rwall_dirx", 32'(dir_x), 0);
        chk("rwall_color", 32'(color_index), 2);
        chk("rwall_top", 32'(logo_top), 112);
        chk("rwall_mode", 32'(mode), 32'(exp_mode(n_ev)));

        t0 = tick_cnt;
        pause = 1'b1;
        run(5);
        pause = 1'b0;
        chk("pause_ticks", 32'(tick_cnt - t0), 5);
        chk("pause_left", 32'(logo_left), 512);
        chk("pause_top", 32'(logo_top), 112);
        chk("pause_color", 32'(color_index), 2);
        chk("pause_dirx", 32'(dir_x), 0);
        chk("pause_mode", 32'(mode), 32'(exp_mode(n_ev)));

        speed = 2'd3;
        pix_cx = 10'd0; pix_cy = 10'd480;
        step();
        pix_cx = 10'd5; pix_cy = 10'd100;
        chk("cor_tick", 32'(c_tick), 1);
        chk("cor_left", 32'(c_left), 512);
        chk("cor_top", 32'(c_top), 0);
        chk("cor_dirx", 32'(c_dir_x), 0);
        chk("cor_diry", 32'(c_dir_y), 1);
        chk("cor_color", 32'(c_color), 1);
        chk("cor_main_left", 32'(logo_left), 512);
        speed = 2'd0;
        step();

        reset = 1'b1; pix_x = 10'd0; pix_y = 10'd480;
        step();
        chk("rstev_tick", 32'(frame_tick), 0);
        chk("rstev_left", 32'(logo_left), 200);
        chk("rstev_top", 32'(logo_top), 200);
        chk("rstev_dirx", 32'(dir_x), 1);
        chk("rstev_diry", 32'(dir_y), 0);
        chk("rstev_color", 32'(color_index), 0);
        chk("rstev_mode", 32'(mode), 0);
        chk("rstev_cor_left", 32'(c_left), 510);
        reset = 1'b0; pix_x = 10'd5; pix_y = 10'd100; n_ev = 0;
        step();
        chk("postrst_left", 32'(logo_left), 200);
        chk("postrst_tick", 32'(frame_tick), 0);

        speed = 2'd1;
        ev();
        chk("spd1_left", 32'(logo_left), 202);
        chk("spd1_top", 32'(logo_top), 198);
        step();
        speed = 2'd0;
        run(118);
        chk("mode_119", 32'(mode), 32'(exp_mode(119)));
        ev();
        chk("mode_120", 32'(mode), 32'(exp_mode(120)));
        step();
        run(359);
        chk("mode_479", 32'(mode), 32'(exp_mode(479)));
        ev();
        chk("mode_480", 32'(mode), 32'(exp_mode(480)));
        chk("mode_evcount", 32'(n_ev), 480);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
